// File: rtl/audio_pkg.sv
// Shared audio definitions: envelope state encoding, volume ceiling and the
// level-to-peak amplitude table used by the note arbiter and tone generators.
package audio_pkg;

  localparam logic [3:0] VOL_MAX = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } env_state_e;

  // Positive square-wave peak for an envelope level. Odd levels use 0x999 in
  // the low 12 bits and even levels 0xFFF, giving roughly 0.6/1.0 steps per
  // high-nibble increment.
  function automatic logic [15:0] amp_of_level(input logic [3:0] level);
    logic [15:0] amp;
    logic [3:0]  lm1;
    amp = '0;
    lm1 = level - 4'd1;
    if (level != 4'd0) begin
      amp = {1'b0, lm1[3:1], (level[0] ? 12'h999 : 12'hFFF)};
    end
    return amp;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Envelope step prescaler: free-running counter 0..STEP_CYCLES-1 that pulses
// step_o for one cycle on the final count.
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset
//   clear_i : synchronous counter clear (restarts the step period)
//   step_o  : one-cycle step strobe
module step_prescaler #(
  parameter int STEP_CYCLES = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic step_o
);

  localparam int CNT_W = $clog2(STEP_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign step_o = (count_q == LAST);

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clear_i || step_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/note_voice_arbiter.sv
// Note voice arbiter: grants the shared tone path to one of N_KEYS keys
// (most-recent press wins, legato fallback to lowest held key) and runs an
// IDLE/ATTACK/SUSTAIN/RELEASE envelope ramping toward the user volume.
//   clk, rst   : system clock, synchronous active-high reset
//   key_req    : debounced key levels, 1 = held
//   volume     : target envelope level 0..15
//   note_valid : a note is sounding (state != IDLE)
//   note_sel   : index of granted key
//   env_level  : current envelope level
//   amp_max    : positive peak for env_level
//   amp_min    : two's-complement negative of amp_max
module note_voice_arbiter
  import audio_pkg::*;
#(
  parameter int N_KEYS      = 3,
  parameter int STEP_CYCLES = 100000,
  parameter int SEL_W       = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_req,
  input  logic [3:0]        volume,
  output logic              note_valid,
  output logic [SEL_W-1:0]  note_sel,
  output logic [3:0]        env_level,
  output logic [15:0]       amp_max,
  output logic [15:0]       amp_min
);

  env_state_e        state_q, state_d;
  logic [3:0]        env_q, env_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [N_KEYS-1:0] key_q;

  logic [N_KEYS-1:0] rise;
  logic              rise_any;
  logic              held_any;
  logic [SEL_W-1:0]  rise_idx;
  logic [SEL_W-1:0]  held_idx;
  logic              granted_held;
  logic              step;
  logic              presc_clr;

  step_prescaler #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_prescaler (
    .clk_i  (clk),
    .rst_i  (rst),
    .clear_i(presc_clr),
    .step_o (step)
  );

  assign rise         = key_req & ~key_q;
  assign granted_held = key_req[sel_q];

  // Lowest-index encoders for new presses and for currently held keys.
  always_comb begin
    rise_any = 1'b0;
    held_any = 1'b0;
    rise_idx = '0;
    held_idx = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      if (rise[i] && !rise_any) begin
        rise_any = 1'b1;
        rise_idx = SEL_W'(i);
      end
      if (key_req[i] && !held_any) begin
        held_any = 1'b1;
        held_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    env_d     = env_q;
    sel_d     = sel_q;
    presc_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        env_d = '0;
        if (rise_any) begin
          state_d   = ST_ATTACK;
          sel_d     = rise_idx;
          presc_clr = 1'b1;
        end
      end
      ST_ATTACK: begin
        if (!held_any) begin
          state_d = ST_RELEASE;
        end else begin
          if (rise_any) begin
            sel_d = rise_idx;
          end else if (!granted_held) begin
            sel_d = held_idx;
          end
          // A fresh press keeps us in ATTACK even if the level is reached.
          if (!rise_any && (env_q >= volume)) begin
            state_d = ST_SUSTAIN;
          end else if (step && (env_q < volume) && (env_q != VOL_MAX)) begin
            env_d = env_q + 4'd1;
          end
        end
      end
      ST_SUSTAIN: begin
        if (rise_any) begin
          state_d = ST_ATTACK;
          sel_d   = rise_idx;
        end else if (!held_any) begin
          state_d = ST_RELEASE;
        end else begin
          if (!granted_held) begin
            sel_d = held_idx;
          end
          if (step) begin
            if ((env_q < volume) && (env_q != VOL_MAX)) begin
              env_d = env_q + 4'd1;
            end else if ((env_q > volume) && (env_q != 4'd0)) begin
              env_d = env_q - 4'd1;
            end
          end
        end
      end
      ST_RELEASE: begin
        if (rise_any) begin
          state_d = ST_ATTACK;
          sel_d   = rise_idx;
        end else if (env_q == 4'd0) begin
          state_d = ST_IDLE;
        end else if (step) begin
          env_d = env_q - 4'd1;
          // Leave on the same edge the level lands at zero.
          if (env_q == 4'd1) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        env_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      env_q   <= '0;
      sel_q   <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      sel_q   <= sel_d;
      key_q   <= key_req;
    end
  end

  assign note_valid = (state_q != ST_IDLE);
  assign note_sel   = sel_q;
  assign env_level  = env_q;
  assign amp_max    = amp_of_level(env_q);
  assign amp_min    = 16'h0000 - amp_max;

endmodule

// File: tb/tb_note_voice_arbiter.sv
// Directed self-checking bench for note_voice_arbiter (N_KEYS=3, STEP_CYCLES=4).
module tb_note_voice_arbiter;
  import audio_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  key_req;
  logic [3:0]  volume;
  logic        note_valid;
  logic [1:0]  note_sel;
  logic [3:0]  env_level;
  logic [15:0] amp_max;
  logic [15:0] amp_min;

  int n_assert = 0;
  int n_fail   = 0;

  note_voice_arbiter #(
    .N_KEYS     (3),
    .STEP_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_req   (key_req),
    .volume    (volume),
    .note_valid(note_valid),
    .note_sel  (note_sel),
    .env_level (env_level),
    .amp_max   (amp_max),
    .amp_min   (amp_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] st(input env_state_e s);
    return 16'(s);
  endfunction

  initial begin
    rst = 1'b1; key_req = 3'b000; volume = 4'd3;
    tick(2);
    check("rst_valid", 16'(note_valid), 16'd0);
    check("rst_sel",   16'(note_sel),   16'd0);
    check("rst_env",   16'(env_level),  16'd0);
    check("rst_amax",  amp_max,         16'h0000);
    check("rst_amin",  amp_min,         16'h0000);
    check("rst_state", 16'(dut.state_q), st(ST_IDLE));

    // Press Do at volume 3: grant on the first edge, ramp every 4 cycles.
    rst = 1'b0; key_req = 3'b001;
    tick(1);
    check("grant_valid", 16'(note_valid), 16'd1);
    check("grant_sel",   16'(note_sel),   16'd0);
    check("grant_amax",  amp_max,         16'h0000);
    check("grant_state", 16'(dut.state_q), st(ST_ATTACK));
    tick(3);
    check("pre_step_amax", amp_max, 16'h0000);
    tick(1);
    check("lvl1_amax", amp_max, 16'h0999);
    tick(4);
    check("lvl2_amax", amp_max, 16'h0FFF);
    tick(4);
    check("lvl3_amax", amp_max, 16'h1999);
    check("lvl3_amin", amp_min, 16'hE667);
    tick(1);
    check("sustain_state", 16'(dut.state_q), st(ST_SUSTAIN));
    tick(3);
    check("sustain_hold", 16'(env_level), 16'd3);

    // Release all at level 3.
    key_req = 3'b000;
    tick(1);
    check("rel_state", 16'(dut.state_q), st(ST_RELEASE));
    check("rel_sel",   16'(note_sel),    16'd0);
    tick(3);
    check("rel_lvl2",   16'(env_level),  16'd2);
    check("rel_valid2", 16'(note_valid), 16'd1);
    tick(4);
    check("rel_lvl1",   16'(env_level),  16'd1);
    check("rel_valid1", 16'(note_valid), 16'd1);
    tick(4);
    check("rel_lvl0",   16'(env_level),  16'd0);
    check("rel_valid0", 16'(note_valid), 16'd0);
    check("rel_idle",   16'(dut.state_q), st(ST_IDLE));

    // Simultaneous Re+Mi rise, then Do pressed on top.
    key_req = 3'b110;
    tick(1);
    check("simul_sel", 16'(note_sel), 16'd1);
    key_req = 3'b111;
    tick(1);
    check("newest_sel",   16'(note_sel),    16'd0);
    check("newest_state", 16'(dut.state_q), st(ST_ATTACK));

    // Legato: Do+Mi held, Do granted; ramp to sustain then drop Do.
    key_req = 3'b101;
    tick(3);
    check("leg_lvl1", 16'(env_level), 16'd1);
    tick(8);
    check("leg_lvl3", 16'(env_level), 16'd3);
    tick(2);
    key_req = 3'b100;
    tick(1);
    check("leg_sel",   16'(note_sel),    16'd2);
    check("leg_amax",  amp_max,          16'h1999);
    check("leg_state", 16'(dut.state_q), st(ST_SUSTAIN));

    // Sustain tracks volume: up to 5, then down to 2.
    volume = 4'd5;
    tick(1);
    check("trk_up4", 16'(env_level), 16'd4);
    tick(4);
    check("trk_up5", 16'(env_level), 16'd5);
    volume = 4'd2;
    tick(4);
    check("trk_dn4", 16'(env_level), 16'd4);
    tick(4);
    check("trk_dn3", 16'(env_level), 16'd3);
    tick(4);
    check("trk_dn2", 16'(env_level), 16'd2);
    volume = 4'd15;
    tick(60);
    check("sat_lvl",  16'(env_level), 16'd15);
    check("sat_amax", amp_max,        16'h7999);
    check("sat_amin", amp_min,        16'h8667);

    // Reset from sustain, then reset during ATTACK at level 2.
    rst = 1'b1; key_req = 3'b000;
    tick(1);
    check("rst2_valid", 16'(note_valid), 16'd0);
    check("rst2_env",   16'(env_level),  16'd0);
    rst = 1'b0; key_req = 3'b010;
    tick(1);
    check("re_sel", 16'(note_sel), 16'd1);
    tick(8);
    check("re_lvl2", 16'(env_level), 16'd2);
    rst = 1'b1;
    tick(1);
    check("abort_valid", 16'(note_valid), 16'd0);
    check("abort_sel",   16'(note_sel),   16'd0);
    check("abort_env",   16'(env_level),  16'd0);
    check("abort_amax",  amp_max,         16'h0000);
    check("abort_state", 16'(dut.state_q), st(ST_IDLE));
    rst = 1'b0;
    tick(1);
    check("held_rise_state", 16'(dut.state_q), st(ST_ATTACK));
    check("held_rise_sel",   16'(note_sel),    16'd1);
    tick(4);
    check("held_rise_lvl1", 16'(env_level), 16'd1);

    // Rise in the same cycle as the granted key's release wins.
    key_req = 3'b001;
    tick(1);
    check("swap_sel",   16'(note_sel),    16'd0);
    check("swap_state", 16'(dut.state_q), st(ST_ATTACK));
    key_req = 3'b000;
    tick(1);
    check("rel2_state", 16'(dut.state_q), st(ST_RELEASE));
    check("rel2_lvl",   16'(env_level),   16'd1);

    // Re-press from RELEASE: level continues, prescaler not restarted.
    key_req = 3'b100;
    tick(1);
    check("rearm_state", 16'(dut.state_q), st(ST_ATTACK));
    check("rearm_sel",   16'(note_sel),    16'd2);
    check("rearm_lvl",   16'(env_level),   16'd1);
    tick(1);
    check("rearm_step", 16'(env_level), 16'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/note_voice_arbiter.md
Name: note_voice_arbiter

Overview:
- Shares the single tone/amplitude path among N_KEYS note keys (Do, Re, Mi, ...). Only one note sounds at a time.
- Picks the note to play and runs a 4-state envelope (IDLE/ATTACK/SUSTAIN/RELEASE) that ramps a level toward the user volume.
- Emits the signed peak pair the tone generator uses for square-wave output.
- Sits between the key debouncers plus volume up/down counter and the audio DAC/tone generator.

Parameters:
- N_KEYS, 3: number of key requesters. Index 0 = Do, 1 = Re, 2 = Mi.
- STEP_CYCLES, 100000: clk cycles per envelope step (1 ms at 100 MHz). Must be >= 2.
- SEL_W, $clog2(N_KEYS) (min 1): width of note_sel.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_req  in  N_KEYS  debounced key levels, 1 = held.
- volume  in  4  target level 0..15 from the volume counter.
- note_valid  out  1  a note is sounding (any state except IDLE).
- note_sel  out  SEL_W  index of the granted key.
- env_level  out  4  current envelope level.
- amp_max  out  16  positive peak = AMP(env_level).
- amp_min  out  16  16'h0000 - amp_max (two's-complement negative peak).

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, env_level=0, note_sel=0, note_valid=0, prescaler=0, key_q=0. Hence amp_max=amp_min=16'h0000. Reset mid-note aborts immediately with no release ramp.
- Registered state: key_q <= key_req every cycle. rise = key_req & ~key_q.
- Key edge response: note_sel, note_valid and state update on the same clk edge that first samples the key change (1-cycle latency).
- Arbitration, most-recent-press wins:
  - Any rise bit set: grant the lowest set rise bit.
  - Granted key drops while other keys are held: grant the lowest-index held key. Keep state and env_level (legato, no retrigger).
  - A rise in the same cycle as the granted key's release: the rise wins.
- Prescaler: free-running counter 0..STEP_CYCLES-1. step=1 for one cycle when count==STEP_CYCLES-1. Counter is cleared on the IDLE->ATTACK transition, so the first step comes STEP_CYCLES cycles after the grant edge.
- IDLE:
  - env_level=0, note_valid=0.
  - Any rise -> ATTACK with the grant as above.
- ATTACK:
  - If env_level >= volume -> SUSTAIN at that edge, no change to env_level.
  - Else on step: env_level+1.
  - No granted key held and no other key held -> RELEASE.
  - A new rise re-grants and stays in ATTACK.
- SUSTAIN:
  - On step: env_level tracks volume by +/-1 per step (volume can change while a key is held).
  - A new rise -> re-grant and go to ATTACK.
  - All keys released -> RELEASE.
- RELEASE:
  - note_valid stays 1 and note_sel holds the last note.
  - On step: env_level-1. When env_level==0 -> IDLE. If env_level is already 0, go to IDLE next edge.
  - A rise -> ATTACK with the new grant. env_level continues from its current value; the prescaler is not cleared.
- env_level saturates at 0 and 15 and never wraps.
- AMP(L), combinational from env_level:
  - L=0 -> 16'h0000.
  - Otherwise high nibble = (L-1)>>1. Low 12 bits = 12'h999 if L is odd, 12'hFFF if L is even.
  - Examples: 1->0999, 2->0FFF, 3->1999, 15->7999.
- amp_min: 16-bit wraparound negation of amp_max, e.g. 0999 -> F667.
- key_req bits at or above N_KEYS do not exist. Simultaneous rises are fully resolved by lowest index.

Decomposition:
- Shared package `audio_pkg`:
  - state enum (IDLE, ATTACK, SUSTAIN, RELEASE).
  - function amp_of_level(L) returning the 16-bit peak.
  - localparam VOL_MAX=4'd15.
  - Other audio blocks use the same table.
- One natural sub-module `step_prescaler`: counter with a sync clear input and a 1-cycle step output.
- Arbiter and envelope FSM stay in the top module.

Test Plan (all with STEP_CYCLES=4, N_KEYS=3):
- Press key0 with volume=3 from reset.
  - Next edge: note_valid=1, note_sel=0, amp_max=0000.
  - amp_max = 0999 after 4 cycles, 0FFF after 8, 1999 after 12, then held in SUSTAIN.
  - amp_min = E667 at level 3.
- Simultaneous rise on key1 and key2 from IDLE -> note_sel=1. Then press key0 while the others stay held -> note_sel=0 the next edge and state=ATTACK.
- Legato: hold key0 and key2, key0 granted last. Release key0 -> note_sel=2, env_level unchanged, no amplitude dip.
- Release all keys at level 3 -> levels 2,1,0 on successive steps with note_valid=1. IDLE and note_valid=0 on the edge the level reaches 0.
- In SUSTAIN at level 5, lower volume to 2 -> levels 4,3,2 over 3 steps. Volume=15 held long -> saturates at 15, amp_max=7999.
- Assert rst during ATTACK at level 2 -> next edge: all outputs 0 and state IDLE. A key still held after reset is treated as a rise and starts ATTACK one cycle after rst deasserts.
